dpd_train_ctrl: RTL and testbench
=================================

Name: dpd_train_ctrl

Overview:
Sequences DPD training runs around the training-signal playback generator and the PA feedback capture path. Per iteration it pulses the generator start and waits for generator latency plus the PA loop delay. It then gates a SIG_LEN-sample feedback capture window and hands the captured buffer to the coefficient estimator via req/ack. It repeats this for a programmed number of iterations, then reports done.

Parameters:
SIG_LEN, 1024, samples per training burst; must be a power of 2; sets cap_addr width.
GEN_LAT, 4, cycles from tx_start assertion to first valid generator sample.
DLY_W, 8, width of loop_delay.
ITER_W, 4, width of iteration count.
TO_CYC, 65535, estimator-ack timeout in cycles; used only with the optional feature.

Ports:
clk  in  1  system clock; all logic on rising edge.
reset  in  1  synchronous, active-high reset.
go  in  1  one-cycle pulse starting a training run; sampled only in IDLE.
abort  in  1  level; terminates the run at the next edge.
iter_num  in  ITER_W  iterations per run; latched on accepted go; 0 treated as 1.
loop_delay  in  DLY_W  PA loop delay in cycles; latched on accepted go.
tx_start  out  1  one-cycle start pulse to the training-signal generator.
cap_en  out  1  capture-buffer write enable.
cap_addr  out  log2(SIG_LEN)  capture-buffer write address.
est_req  out  1  request to the estimator; buffer is valid while high.
est_ack  in  1  estimator done; one-cycle pulse.
iter_cnt  out  ITER_W  index of the current iteration, starting at 0.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse when all iterations are complete.
err  out  1  sticky timeout flag; always 0 without the optional feature.

Behaviour:
- Reset values (any state, including mid-run): FSM=IDLE, and tx_start, cap_en, cap_addr, est_req, iter_cnt, busy, done, err all 0. Internal counters are cleared.
- All outputs are registered.
- FSM states: IDLE, START, WAIT, CAPT, EST, DONE.
- IDLE: on go=1, latch iter_num and loop_delay, then go to START.
- START: tx_start=1 for exactly one cycle, load the wait counter with GEN_LAT+loop_delay-1, then go to WAIT.
- WAIT: decrement each cycle; on reaching 0, go to CAPT.
  - The first cap_en cycle is exactly GEN_LAT+loop_delay cycles after the tx_start cycle.
  - loop_delay=0 is legal and gives a GEN_LAT-cycle gap.
- CAPT: cap_en=1 for exactly SIG_LEN consecutive cycles; cap_addr counts 0..SIG_LEN-1.
  - After the last sample, cap_en falls and cap_addr returns to 0.
  - Then go to EST.
- EST: est_req=1 until est_ack is sampled high. On that cycle est_req drops at the next edge.
  - If iter_cnt == latched iterations-1, go to DONE.
  - Otherwise increment iter_cnt and go to START.
- DONE: done=1 for one cycle, iter_cnt cleared, then go to IDLE.
- est_ack is ignored outside EST; go is ignored outside IDLE.
- go and est_ack in the same cycle: est_ack is handled and go is dropped.
- abort=1 in any non-IDLE state:
  - Next state is IDLE; all outputs are cleared next cycle.
  - done is not pulsed, and err is unchanged.
  - Abort wins over est_ack in the same cycle.
- busy=1 from the cycle after an accepted go until IDLE is re-entered.
- Counters wrap nowhere: the GEN_LAT+loop_delay sum is sized DLY_W+1 bits.

Optional Feature:
Macro DPD_TRAIN_TIMEOUT_EN.
- Enabled: a 16-bit counter runs while in EST. If TO_CYC cycles elapse without est_ack:
  - err is set (sticky until reset or the next accepted go, which clears it).
  - est_req drops and the FSM goes to IDLE with no done pulse.
- Disabled: EST waits indefinitely; err is tied to 0; no counter logic is present.

Test Plan:
- Single run: iter_num=1, loop_delay=10, go, est_ack 5 cycles after est_req.
  - tx_start at cycle T; first cap_en at T+14.
  - cap_en high 1024 cycles, cap_addr 0..1023.
  - est_req high 5 cycles; done 1 cycle after ack; busy then falls.
- Multi-iteration: iter_num=3, loop_delay=0.
  - Three tx_start pulses; iter_cnt goes 0,1,2.
  - Each cap_en window starts exactly 4 cycles after its tx_start.
  - Exactly one done pulse.
- iter_num=0: behaves as 1 iteration; single done.
- Abort during CAPT at cap_addr=500: next cycle cap_en=0, busy=0, no done. A new go then restarts cleanly with iter_cnt=0.
- Synchronous reset asserted in EST with est_req=1: all outputs 0 after the edge. A spurious est_ack afterward is ignored and no done occurs.
- DPD_TRAIN_TIMEOUT_EN with TO_CYC=100 and no est_ack:
  - err=1 and est_req=0 after 100 EST cycles; FSM back to IDLE; no done.
  - Next go clears err.

Source files
------------

// File: rtl/dpd_train_ctrl.sv
// DPD training sequencer: generator start, loop-delay wait, feedback capture window,
// estimator handshake, repeated per iteration. Optional ack timeout: DPD_TRAIN_TIMEOUT_EN.
module dpd_train_ctrl #(
    parameter int SIG_LEN = 1024,
    parameter int GEN_LAT = 4,
    parameter int DLY_W   = 8,
    parameter int ITER_W  = 4,
    parameter int TO_CYC  = 65535
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       go,
    input  logic                       abort,
    input  logic [ITER_W-1:0]          iter_num,
    input  logic [DLY_W-1:0]           loop_delay,
    output logic                       tx_start,
    output logic                       cap_en,
    output logic [$clog2(SIG_LEN)-1:0] cap_addr,
    output logic                       est_req,
    input  logic                       est_ack,
    output logic [ITER_W-1:0]          iter_cnt,
    output logic                       busy,
    output logic                       done,
    output logic                       err
);

    localparam int AW = $clog2(SIG_LEN);
    localparam int CW = DLY_W + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_WAIT  = 3'd2,
        S_CAPT  = 3'd3,
        S_EST   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t            state_r;
    state_t            state_nx;
    logic [CW-1:0]     wait_r;
    logic [CW-1:0]     wait_nx;
    logic [AW-1:0]     cap_addr_r;
    logic [AW-1:0]     cap_addr_nx;
    logic [ITER_W-1:0] iter_cnt_r;
    logic [ITER_W-1:0] iter_cnt_nx;
    logic [ITER_W-1:0] iter_lat_r;
    logic [DLY_W-1:0]  dly_lat_r;
    logic              tx_start_r;
    logic              cap_en_r;
    logic              est_req_r;
    logic              busy_r;
    logic              done_r;
    logic              go_acc_s;
    logic [CW-1:0]     lat_sum_s;
    logic [ITER_W-1:0] iter_last_s;

`ifdef DPD_TRAIN_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TO_CYC - 1);
    logic [15:0] to_r;
    logic        to_fire_s;
    logic        err_r;
`endif

    assign go_acc_s    = (state_r == S_IDLE) && go;
    assign lat_sum_s   = CW'(GEN_LAT) + {1'b0, dly_lat_r};
    // A zero iteration count runs a single iteration.
    assign iter_last_s = (iter_lat_r == {ITER_W{1'b0}}) ? {ITER_W{1'b0}} : (iter_lat_r - {{(ITER_W-1){1'b0}}, 1'b1});

    // Next-state and next-counter logic; abort overrides everything outside IDLE.
    always_comb begin
        state_nx    = state_r;
        wait_nx     = wait_r;
        cap_addr_nx = {AW{1'b0}};
        iter_cnt_nx = iter_cnt_r;
`ifdef DPD_TRAIN_TIMEOUT_EN
        to_fire_s   = 1'b0;
`endif
        case (state_r)
            S_IDLE: begin
                if (go) begin
                    state_nx = S_START;
                end else begin
                    state_nx = S_IDLE;
                end
            end
            S_START: begin
                wait_nx = lat_sum_s - CW'(1);
                if (lat_sum_s <= CW'(1)) begin
                    state_nx = S_CAPT;
                end else begin
                    state_nx = S_WAIT;
                end
            end
            S_WAIT: begin
                wait_nx = wait_r - CW'(1);
                if (wait_r <= CW'(1)) begin
                    state_nx = S_CAPT;
                end else begin
                    state_nx = S_WAIT;
                end
            end
            S_CAPT: begin
                if (cap_addr_r == AW'(SIG_LEN - 1)) begin
                    state_nx = S_EST;
                end else begin
                    cap_addr_nx = cap_addr_r + AW'(1);
                    state_nx    = S_CAPT;
                end
            end
            S_EST: begin
                if (est_ack) begin
                    if (iter_cnt_r == iter_last_s) begin
                        state_nx = S_DONE;
                    end else begin
                        iter_cnt_nx = iter_cnt_r + ITER_W'(1);
                        state_nx    = S_START;
                    end
                end
`ifdef DPD_TRAIN_TIMEOUT_EN
                else if (to_r == TO_LAST) begin
                    to_fire_s = 1'b1;
                    state_nx  = S_IDLE;
                end
`endif
                else begin
                    state_nx = S_EST;
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase

        if (abort && (state_r != S_IDLE)) begin
            state_nx    = S_IDLE;
            wait_nx     = {CW{1'b0}};
            cap_addr_nx = {AW{1'b0}};
`ifdef DPD_TRAIN_TIMEOUT_EN
            to_fire_s   = 1'b0;
`endif
        end else begin
            state_nx = state_nx;
        end

        if ((state_nx == S_IDLE) || (state_nx == S_DONE)) begin
            iter_cnt_nx = {ITER_W{1'b0}};
        end else begin
            iter_cnt_nx = iter_cnt_nx;
        end
    end

    // State, counters, run parameters and registered outputs decoded from next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= S_IDLE;
            wait_r     <= {CW{1'b0}};
            cap_addr_r <= {AW{1'b0}};
            iter_cnt_r <= {ITER_W{1'b0}};
            iter_lat_r <= {ITER_W{1'b0}};
            dly_lat_r  <= {DLY_W{1'b0}};
            tx_start_r <= 1'b0;
            cap_en_r   <= 1'b0;
            est_req_r  <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_nx;
            wait_r     <= wait_nx;
            cap_addr_r <= cap_addr_nx;
            iter_cnt_r <= iter_cnt_nx;
            iter_lat_r <= go_acc_s ? iter_num : iter_lat_r;
            dly_lat_r  <= go_acc_s ? loop_delay : dly_lat_r;
            tx_start_r <= (state_nx == S_START);
            cap_en_r   <= (state_nx == S_CAPT);
            est_req_r  <= (state_nx == S_EST);
            busy_r     <= (state_nx != S_IDLE);
            done_r     <= (state_nx == S_DONE);
        end
    end

`ifdef DPD_TRAIN_TIMEOUT_EN
    // Estimator timeout counter and sticky error, cleared by the next accepted go.
    always_ff @(posedge clk) begin
        if (reset) begin
            to_r  <= 16'd0;
            err_r <= 1'b0;
        end else begin
            to_r <= ((state_r == S_EST) && (state_nx == S_EST)) ? (to_r + 16'd1) : 16'd0;
            if (go_acc_s) begin
                err_r <= 1'b0;
            end else if (to_fire_s) begin
                err_r <= 1'b1;
            end else begin
                err_r <= err_r;
            end
        end
    end
    assign err = err_r;
`else
    assign err = 1'b0;
`endif

    assign tx_start = tx_start_r;
    assign cap_en   = cap_en_r;
    assign cap_addr = cap_addr_r;
    assign est_req  = est_req_r;
    assign iter_cnt = iter_cnt_r;
    assign busy     = busy_r;
    assign done     = done_r;

endmodule

// File: tb/tb_dpd_train_ctrl.sv
// Directed self-checking bench for dpd_train_ctrl (SIG_LEN=1024, GEN_LAT=4).
module tb_dpd_train_ctrl;

`ifdef DPD_TRAIN_TIMEOUT_EN
    localparam int TO = 100;
`else
    localparam int TO = 65535;
`endif

    logic       clk;
    logic       reset;
    logic       go;
    logic       abort;
    logic [3:0] iter_num;
    logic [7:0] loop_delay;
    logic       tx_start;
    logic       cap_en;
    logic [9:0] cap_addr;
    logic       est_req;
    logic       est_ack;
    logic [3:0] iter_cnt;
    logic       busy;
    logic       done;
    logic       err;

    int passed = 0;
    int total  = 0;
    int done_cnt = 0;

    dpd_train_ctrl #(
        .SIG_LEN(1024), .GEN_LAT(4), .DLY_W(8), .ITER_W(4), .TO_CYC(TO)
    ) dut (
        .clk(clk), .reset(reset), .go(go), .abort(abort),
        .iter_num(iter_num), .loop_delay(loop_delay),
        .tx_start(tx_start), .cap_en(cap_en), .cap_addr(cap_addr),
        .est_req(est_req), .est_ack(est_ack), .iter_cnt(iter_cnt),
        .busy(busy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    task automatic step();
        @(negedge clk);
    endtask

    // which: 0 cap_en high, 1 est_req high, 2 cap_addr==500 in capture, 3 cap_en low
    task automatic wait_until(input int which, input int bound, output int k, output bit ok);
        ok = 1'b0;
        k  = 0;
        while (!ok && k < bound) begin
            step();
            k++;
            case (which)
                0: ok = (cap_en === 1'b1);
                1: ok = (est_req === 1'b1);
                2: ok = (cap_en === 1'b1) && (cap_addr === 10'd500);
                3: ok = (cap_en === 1'b0);
                default: ok = 1'b1;
            endcase
        end
    endtask

    task automatic start_run(input logic [3:0] n, input logic [7:0] d);
        iter_num = n;
        loop_delay = d;
        go = 1'b1;
        step();
        go = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        total++;
        if ({tx_start, cap_en, cap_addr, est_req, iter_cnt, busy, done, err} !== 21'd0)
            $display("FAIL reset_outputs: got %h expected 0", {tx_start, cap_en, cap_addr, est_req, iter_cnt, busy, done, err});
        else passed++;
    endtask

    task automatic test_single();
        int k; bit ok; int n; int errs; int d0; logic [9:0] a;
        d0 = done_cnt;
        start_run(4'd1, 8'd10);
        total++;
        if ({tx_start, busy} !== 2'b11) $display("FAIL single_tx_start: got %b expected 11", {tx_start, busy});
        else passed++;
        wait_until(0, 100, k, ok);
        total++;
        if (!ok || k != 14) $display("FAIL single_gap: got %0d expected 14", k);
        else passed++;
        n = 0; errs = 0;
        while (cap_en === 1'b1 && n < 2000) begin
            a = 10'(n);
            if (cap_addr !== a) errs++;
            n++;
            step();
        end
        total++;
        if (n != 1024 || errs != 0) $display("FAIL single_capture: got len %0d addr_errs %0d expected len 1024 addr_errs 0", n, errs);
        else passed++;
        total++;
        if ({est_req, cap_addr} !== {1'b1, 10'd0}) $display("FAIL single_est_entry: got req %b addr %0d expected req 1 addr 0", est_req, cap_addr);
        else passed++;
        repeat (4) step();
        total++;
        if (est_req !== 1'b1) $display("FAIL single_req_hold: got %b expected 1", est_req);
        else passed++;
        est_ack = 1'b1;
        step();
        est_ack = 1'b0;
        total++;
        if ({est_req, done, busy} !== 3'b011) $display("FAIL single_done: got %b expected 011", {est_req, done, busy});
        else passed++;
        step();
        total++;
        if ({done, busy, err} !== 3'b000 || done_cnt - d0 != 1) $display("FAIL single_idle: got %b dones %0d expected 000 dones 1", {done, busy, err}, done_cnt - d0);
        else passed++;
    endtask

    task automatic test_multi();
        int k; bit ok; int d0; int gap_bad; int it_bad;
        d0 = done_cnt; gap_bad = 0; it_bad = 0;
        start_run(4'd3, 8'd0);
        for (int it = 0; it < 3; it++) begin
            if (tx_start !== 1'b1 || iter_cnt !== 4'(it)) it_bad++;
            wait_until(0, 100, k, ok);
            if (!ok || k != 4) gap_bad++;
            wait_until(3, 2000, k, ok);
            est_ack = 1'b1;
            go = (it == 0);
            step();
            est_ack = 1'b0;
            go = 1'b0;
        end
        total++;
        if (it_bad != 0) $display("FAIL multi_iter_cnt: got %0d bad iterations expected 0", it_bad);
        else passed++;
        total++;
        if (gap_bad != 0) $display("FAIL multi_gap: got %0d bad gaps expected 0", gap_bad);
        else passed++;
        total++;
        if (done !== 1'b1) $display("FAIL multi_done: got %b expected 1", done);
        else passed++;
        step();
        total++;
        if (busy !== 1'b0 || done_cnt - d0 != 1) $display("FAIL multi_single_done: got busy %b dones %0d expected busy 0 dones 1", busy, done_cnt - d0);
        else passed++;
    endtask

    task automatic test_iter_zero();
        int k; bit ok; int d0;
        d0 = done_cnt;
        start_run(4'd0, 8'd2);
        wait_until(0, 100, k, ok);
        total++;
        if (!ok || k != 6) $display("FAIL zero_gap: got %0d expected 6", k);
        else passed++;
        wait_until(3, 2000, k, ok);
        est_ack = 1'b1;
        step();
        est_ack = 1'b0;
        total++;
        if ({done, tx_start} !== 2'b10) $display("FAIL zero_done: got %b expected 10", {done, tx_start});
        else passed++;
        step(); step();
        total++;
        if (busy !== 1'b0 || done_cnt - d0 != 1) $display("FAIL zero_single_done: got busy %b dones %0d expected busy 0 dones 1", busy, done_cnt - d0);
        else passed++;
    endtask

    task automatic test_abort();
        int k; bit ok; int d0;
        d0 = done_cnt;
        start_run(4'd2, 8'd3);
        wait_until(2, 2000, k, ok);
        total++;
        if (!ok) $display("FAIL abort_reach_500: got timeout expected cap_addr 500");
        else passed++;
        abort = 1'b1;
        step();
        abort = 1'b0;
        total++;
        if ({cap_en, busy, cap_addr, tx_start, iter_cnt} !== 17'd0) $display("FAIL abort_clear: got %h expected 0", {cap_en, busy, cap_addr, tx_start, iter_cnt});
        else passed++;
        start_run(4'd1, 8'd1);
        total++;
        if ({tx_start, iter_cnt} !== 5'b10000) $display("FAIL abort_restart: got %b expected 10000", {tx_start, iter_cnt});
        else passed++;
        wait_until(0, 100, k, ok);
        total++;
        if (!ok || k != 5) $display("FAIL abort_restart_gap: got %0d expected 5", k);
        else passed++;
        wait_until(3, 2000, k, ok);
        est_ack = 1'b1;
        abort = 1'b1;
        step();
        est_ack = 1'b0;
        abort = 1'b0;
        step(); step();
        total++;
        if ({est_req, busy, done} !== 3'b000 || done_cnt != d0) $display("FAIL abort_over_ack: got %b dones %0d expected 000 dones 0", {est_req, busy, done}, done_cnt - d0);
        else passed++;
    endtask

    task automatic test_reset_in_est();
        int k; bit ok; int d0;
        d0 = done_cnt;
        start_run(4'd1, 8'd0);
        wait_until(1, 2000, k, ok);
        total++;
        if (!ok) $display("FAIL rst_reach_est: got timeout expected est_req 1");
        else passed++;
        reset = 1'b1;
        step();
        reset = 1'b0;
        total++;
        if ({tx_start, cap_en, cap_addr, est_req, iter_cnt, busy, done, err} !== 21'd0)
            $display("FAIL rst_in_est: got %h expected 0", {tx_start, cap_en, cap_addr, est_req, iter_cnt, busy, done, err});
        else passed++;
        est_ack = 1'b1;
        step();
        est_ack = 1'b0;
        step(); step();
        total++;
        if ({busy, est_req, tx_start} !== 3'b000 || done_cnt != d0) $display("FAIL rst_spurious_ack: got %b dones %0d expected 000 dones 0", {busy, est_req, tx_start}, done_cnt - d0);
        else passed++;
    endtask

`ifdef DPD_TRAIN_TIMEOUT_EN
    task automatic test_timeout();
        int k; bit ok; int n; int d0;
        d0 = done_cnt;
        start_run(4'd1, 8'd0);
        wait_until(1, 2000, k, ok);
        n = 0;
        while (est_req === 1'b1 && n < 300) begin
            n++;
            step();
        end
        total++;
        if (n != 100) $display("FAIL to_req_len: got %0d expected 100", n);
        else passed++;
        step();
        total++;
        if ({err, busy, done} !== 3'b100 || done_cnt != d0) $display("FAIL to_err: got %b dones %0d expected 100 dones 0", {err, busy, done}, done_cnt - d0);
        else passed++;
        start_run(4'd1, 8'd0);
        total++;
        if ({err, tx_start} !== 2'b01) $display("FAIL to_err_clear: got %b expected 01", {err, tx_start});
        else passed++;
        abort = 1'b1;
        step();
        abort = 1'b0;
    endtask
`endif

    initial begin
        reset = 1'b0; go = 1'b0; abort = 1'b0; est_ack = 1'b0;
        iter_num = 4'd0; loop_delay = 8'd0;
        test_reset();
        test_single();
        test_multi();
        test_iter_zero();
        test_abort();
        test_reset_in_est();
`ifdef DPD_TRAIN_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
